// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forward-select codes and FSM states.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10,
    FLUSH    = 2'b11
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of hazard_ctrl datapath signals; perf counters exist only with HAZARD_PERF_EN.
interface hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] rs_dec, rt_dec, rs_ex, rt_ex, rd_ex, rw_mem, rw_wb;
  logic             ex_memread, mem_regwrite, wb_regwrite, mem_req, dhit, redirect;
  logic             freeze_fd, freeze_dex, freeze_xm, flush_fd, flush_dex;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport hc (
    input  rs_dec, rt_dec, rs_ex, rt_ex, rd_ex, rw_mem, rw_wb,
    input  ex_memread, mem_regwrite, wb_regwrite, mem_req, dhit, redirect,
    output freeze_fd, freeze_dex, freeze_xm, flush_fd, flush_dex,
    output fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );
  modport tb (
    output rs_dec, rt_dec, rs_ex, rt_ex, rd_ex, rw_mem, rw_wb,
    output ex_memread, mem_regwrite, wb_regwrite, mem_req, dhit, redirect,
    input  freeze_fd, freeze_dex, freeze_xm, flush_fd, flush_dex,
    input  fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );
`else
  modport hc (
    input  rs_dec, rt_dec, rs_ex, rt_ex, rd_ex, rw_mem, rw_wb,
    input  ex_memread, mem_regwrite, wb_regwrite, mem_req, dhit, redirect,
    output freeze_fd, freeze_dex, freeze_xm, flush_fd, flush_dex,
    output fwd_a_sel, fwd_b_sel
  );
  modport tb (
    output rs_dec, rt_dec, rs_ex, rt_ex, rd_ex, rw_mem, rw_wb,
    output ex_memread, mem_regwrite, wb_regwrite, mem_req, dhit, redirect,
    input  freeze_fd, freeze_dex, freeze_xm, flush_fd, flush_dex,
    input  fwd_a_sel, fwd_b_sel
  );
`endif
endinterface

// File: rtl/hazard_fwd.sv
// Combinational ALU operand forward select for one source register; MEM beats WB, r0 never forwards.
module hazard_fwd
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src_ex,
  input  logic [REG_W-1:0] rw_mem,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] rw_wb,
  input  logic             wb_regwrite,
  output fwd_sel_t         sel
);

  // Pick the youngest in-flight producer of src_ex.
  always_comb begin
    if (mem_regwrite && (rw_mem != {REG_W{1'b0}}) && (rw_mem == src_ex)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite && (rw_wb != {REG_W{1'b0}}) && (rw_wb == src_ex)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, D-cache miss freeze, redirect flush, operand forwarding.
// Optional saturating perf counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W        = 5,
  parameter int LU_CYCLES    = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [REG_W-1:0] rs_dec,
  input  logic [REG_W-1:0] rt_dec,
  input  logic [REG_W-1:0] rs_ex,
  input  logic [REG_W-1:0] rt_ex,
  input  logic [REG_W-1:0] rd_ex,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] rw_mem,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] rw_wb,
  input  logic             wb_regwrite,
  input  logic             mem_req,
  input  logic             dhit,
  input  logic             redirect,
  output logic             freeze_fd,
  output logic             freeze_dex,
  output logic             freeze_xm,
  output logic             flush_fd,
  output logic             flush_dex,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  if (LU_CYCLES < 1 || LU_CYCLES > 3 || FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3 || CNT_W < 1)
  begin : g_param_range
    $error("hazard_ctrl: parameter out of range");
  end

  localparam logic [1:0] LU_RELOAD = 2'(LU_CYCLES - 1);
  localparam logic [1:0] FL_RELOAD = 2'(FLUSH_CYCLES - 1);

  hz_state_t  state_r, state_nx_s;
  logic [1:0] lu_cnt_r, lu_cnt_nx_s, fl_cnt_r, fl_cnt_nx_s;
  logic       redir_pend_r, redir_pend_nx_s;
  logic       miss_s, lu_s, run_like_s, run_redir_s;
  logic       frz_fd_s, frz_dex_s, frz_xm_s, fl_fd_s, fl_dex_s, redir_svc_s;
  fwd_sel_t   fwd_a_s, fwd_b_s;

  assign miss_s = mem_req & ~dhit;
  assign lu_s   = ex_memread & (rd_ex != {REG_W{1'b0}}) & ((rd_ex == rs_dec) | (rd_ex == rt_dec));

  // Decide whether this cycle is evaluated with idle-pipeline rules and which redirect applies.
  always_comb begin
    run_like_s  = 1'b0;
    run_redir_s = redirect;
    case (state_r)
      RUN:      run_like_s = 1'b1;
      LU_STALL: run_like_s = miss_s | redirect;
      MEM_WAIT: begin
        run_like_s  = ~miss_s;
        run_redir_s = redir_pend_r | redirect;
      end
      FLUSH:    run_like_s = ~miss_s & redirect;
      default:  run_like_s = 1'b1;
    endcase
  end

  // Next-state and same-cycle latch controls.
  always_comb begin
    state_nx_s      = state_r;
    lu_cnt_nx_s     = lu_cnt_r;
    fl_cnt_nx_s     = fl_cnt_r;
    redir_pend_nx_s = redir_pend_r;
    frz_fd_s        = 1'b0;
    frz_dex_s       = 1'b0;
    frz_xm_s        = 1'b0;
    fl_fd_s         = 1'b0;
    fl_dex_s        = 1'b0;
    redir_svc_s     = 1'b0;
    if (run_like_s) begin
      redir_pend_nx_s = miss_s & redirect;
      lu_cnt_nx_s     = 2'd0;
      fl_cnt_nx_s     = 2'd0;
      if (miss_s) begin
        {frz_fd_s, frz_dex_s, frz_xm_s} = 3'b111;
        state_nx_s = MEM_WAIT;
      end else if (run_redir_s) begin
        {fl_fd_s, fl_dex_s} = 2'b11;
        redir_svc_s = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_nx_s  = FLUSH;
          fl_cnt_nx_s = FL_RELOAD;
        end else begin
          state_nx_s = RUN;
        end
      end else if (lu_s) begin
        frz_fd_s = 1'b1;
        fl_dex_s = 1'b1;
        if (LU_CYCLES > 1) begin
          state_nx_s  = LU_STALL;
          lu_cnt_nx_s = LU_RELOAD;
        end else begin
          state_nx_s = RUN;
        end
      end else begin
        state_nx_s = RUN;
      end
    end else begin
      case (state_r)
        LU_STALL: begin
          frz_fd_s = 1'b1;
          fl_dex_s = 1'b1;
          if (lu_cnt_r <= 2'd1) begin
            state_nx_s  = RUN;
            lu_cnt_nx_s = 2'd0;
          end else begin
            lu_cnt_nx_s = lu_cnt_r - 2'd1;
          end
        end
        MEM_WAIT: begin
          {frz_fd_s, frz_dex_s, frz_xm_s} = 3'b111;
          redir_pend_nx_s = redir_pend_r | redirect;
        end
        FLUSH: begin
          if (miss_s) begin
            {frz_fd_s, frz_dex_s, frz_xm_s} = 3'b111;
            state_nx_s      = MEM_WAIT;
            redir_pend_nx_s = 1'b0;
            fl_cnt_nx_s     = 2'd0;
          end else begin
            fl_fd_s = 1'b1;
            if (fl_cnt_r <= 2'd1) begin
              state_nx_s  = RUN;
              fl_cnt_nx_s = 2'd0;
            end else begin
              fl_cnt_nx_s = fl_cnt_r - 2'd1;
            end
          end
        end
        default: state_nx_s = RUN;
      endcase
    end
  end

  // State, countdowns and deferred-redirect flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r      <= RUN;
      lu_cnt_r     <= 2'd0;
      fl_cnt_r     <= 2'd0;
      redir_pend_r <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      lu_cnt_r     <= lu_cnt_nx_s;
      fl_cnt_r     <= fl_cnt_nx_s;
      redir_pend_r <= redir_pend_nx_s;
    end
  end

  // Controls are forced quiet while reset is asserted, even mid-cycle.
  assign freeze_fd  = frz_fd_s  & ~RST;
  assign freeze_dex = frz_dex_s & ~RST;
  assign freeze_xm  = frz_xm_s  & ~RST;
  assign flush_fd   = fl_fd_s   & ~RST;
  assign flush_dex  = fl_dex_s  & ~RST;

  hazard_fwd #(.REG_W(REG_W)) u_fwd_a (
    .src_ex(rs_ex), .rw_mem(rw_mem), .mem_regwrite(mem_regwrite),
    .rw_wb(rw_wb), .wb_regwrite(wb_regwrite), .sel(fwd_a_s)
  );

  hazard_fwd #(.REG_W(REG_W)) u_fwd_b (
    .src_ex(rt_ex), .rw_mem(rw_mem), .mem_regwrite(mem_regwrite),
    .rw_wb(rw_wb), .wb_regwrite(wb_regwrite), .sel(fwd_b_s)
  );

  assign fwd_a_sel = fwd_a_s;
  assign fwd_b_sel = fwd_b_s;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  // Saturating counts of frozen cycles and serviced redirects.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if ((frz_fd_s | frz_dex_s | frz_xm_s) && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (redir_svc_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  logic unused_s;
  assign unused_s = redir_svc_s;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (LU_CYCLES=2, FLUSH_CYCLES=3); counters checked with HAZARD_PERF_EN.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int REG_W = 5;
  localparam int LU    = 2;
  localparam int FL    = 3;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic             frz_fd, frz_dex, frz_xm, fl_fd, fl_dex;
    logic [1:0]       fa, fb;
    logic [CNT_W-1:0] sc, fc;
  } obs_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) ifc ();

  hazard_ctrl #(.REG_W(REG_W), .LU_CYCLES(LU), .FLUSH_CYCLES(FL), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .rs_dec(ifc.rs_dec), .rt_dec(ifc.rt_dec), .rs_ex(ifc.rs_ex), .rt_ex(ifc.rt_ex),
    .rd_ex(ifc.rd_ex), .ex_memread(ifc.ex_memread), .rw_mem(ifc.rw_mem),
    .mem_regwrite(ifc.mem_regwrite), .rw_wb(ifc.rw_wb), .wb_regwrite(ifc.wb_regwrite),
    .mem_req(ifc.mem_req), .dhit(ifc.dhit), .redirect(ifc.redirect),
    .freeze_fd(ifc.freeze_fd), .freeze_dex(ifc.freeze_dex), .freeze_xm(ifc.freeze_xm),
    .flush_fd(ifc.flush_fd), .flush_dex(ifc.flush_dex),
    .fwd_a_sel(ifc.fwd_a_sel), .fwd_b_sel(ifc.fwd_b_sel)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(ifc.stall_cnt), .flush_cnt(ifc.flush_cnt)
`endif
  );

  obs_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: remaining bubble / flush cycles, waiting-on-miss flag, deferred redirect.
  int               m_lu = 0, m_fl = 0;
  bit               m_wait = 1'b0, m_pend = 1'b0;
  logic [CNT_W-1:0] m_sc = '0, m_fc = '0;

  function automatic logic [1:0] fsel(input logic [REG_W-1:0] src);
    if (src != 0 && ifc.mem_regwrite && ifc.rw_mem == src) return 2'b01;
    if (src != 0 && ifc.wb_regwrite && ifc.rw_wb == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic push_exp();
    obs_t e;
    bit miss, lu, redir_now, busy;
    e    = '0;
    e.fa = fsel(ifc.rs_ex);
    e.fb = fsel(ifc.rt_ex);
    if (RST) begin
      m_lu = 0; m_fl = 0; m_wait = 0; m_pend = 0; m_sc = '0; m_fc = '0;
    end else begin
`ifdef HAZARD_PERF_EN
      e.sc = m_sc;
      e.fc = m_fc;
`endif
      miss = ifc.mem_req && !ifc.dhit;
      lu   = ifc.ex_memread && ifc.rd_ex != 0 &&
             (ifc.rd_ex == ifc.rs_dec || ifc.rd_ex == ifc.rt_dec);
      redir_now = ifc.redirect;
      busy = 1'b0;
      if (miss) begin
        e.frz_fd = 1; e.frz_dex = 1; e.frz_xm = 1; busy = 1'b1;
        if (m_wait) m_pend = m_pend | ifc.redirect;
        else        m_pend = (m_fl == 0) && ifc.redirect;
        m_wait = 1; m_lu = 0; m_fl = 0;
      end else if (m_wait) begin
        redir_now = m_pend || ifc.redirect;
        m_wait = 0; m_pend = 0;
      end
      if (!busy) begin
        if (redir_now) begin
          e.fl_fd = 1; e.fl_dex = 1; m_fl = FL - 1; m_lu = 0;
          if (m_fc != {CNT_W{1'b1}}) m_fc++;
        end else if (m_fl > 0) begin
          e.fl_fd = 1; m_fl--;
        end else if (m_lu > 0) begin
          e.frz_fd = 1; e.fl_dex = 1; m_lu--;
        end else if (lu) begin
          e.frz_fd = 1; e.fl_dex = 1; m_lu = LU - 1;
        end
      end
      if ((e.frz_fd || e.frz_dex || e.frz_xm) && m_sc != {CNT_W{1'b1}}) m_sc++;
    end
    sb.push_back(e);
  endtask

  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ifc.rs_dec = 0; ifc.rt_dec = 0; ifc.rs_ex = 0; ifc.rt_ex = 0; ifc.rd_ex = 0;
    ifc.rw_mem = 0; ifc.rw_wb = 0; ifc.ex_memread = 0; ifc.mem_regwrite = 0;
    ifc.wb_regwrite = 0; ifc.mem_req = 0; ifc.dhit = 0; ifc.redirect = 0;
  endtask

  // Monitor: every cycle the DUT presents controls; compare against the oldest expectation.
  always @(negedge CLK) begin
    obs_t a, e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      a = '0;
      a.frz_fd = ifc.freeze_fd; a.frz_dex = ifc.freeze_dex; a.frz_xm = ifc.freeze_xm;
      a.fl_fd  = ifc.flush_fd;  a.fl_dex  = ifc.flush_dex;
      a.fa = ifc.fwd_a_sel; a.fb = ifc.fwd_b_sel;
`ifdef HAZARD_PERF_EN
      a.sc = ifc.stall_cnt; a.fc = ifc.flush_cnt;
`endif
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL ctrl t=%0t actual frz=%b%b%b fl=%b%b fa=%b fb=%b sc=%0d fc=%0d required frz=%b%b%b fl=%b%b fa=%b fb=%b sc=%0d fc=%0d",
                 $time, a.frz_fd, a.frz_dex, a.frz_xm, a.fl_fd, a.fl_dex, a.fa, a.fb, a.sc, a.fc,
                 e.frz_fd, e.frz_dex, e.frz_xm, e.fl_fd, e.fl_dex, e.fa, e.fb, e.sc, e.fc);
      end
    end
  end

  initial begin
    RST = 1'b1;
    idle();
    // Reset state
    for (int i = 0; i < 2; i++) begin next(); push_exp(); end
    next(); RST = 1'b0; push_exp();

    // Load-use with LU_CYCLES=2, load leaves execute after the bubbles
    for (int i = 0; i < 2; i++) begin
      next(); ifc.ex_memread = 1; ifc.rd_ex = 5; ifc.rs_dec = 5; push_exp();
    end
    for (int i = 0; i < 2; i++) begin next(); idle(); push_exp(); end

    // Double forward: MEM wins over WB, then register 0
    next(); ifc.rs_ex = 3; ifc.rt_ex = 3; ifc.rw_mem = 3; ifc.mem_regwrite = 1;
    ifc.rw_wb = 3; ifc.wb_regwrite = 1; push_exp();
    next(); ifc.rw_mem = 0; ifc.rs_ex = 0; push_exp();
    next(); ifc.rw_wb = 0; ifc.rw_mem = 3; ifc.rs_ex = 3; ifc.mem_regwrite = 0; push_exp();

    // Miss for 4 cycles with redirect in cycle 2, then dhit
    for (int i = 0; i < 4; i++) begin
      next(); idle(); ifc.mem_req = 1; ifc.redirect = (i == 1); push_exp();
    end
    next(); idle(); ifc.mem_req = 1; ifc.dhit = 1; push_exp();
    for (int i = 0; i < 4; i++) begin next(); idle(); push_exp(); end

    // Redirect pulse with FLUSH_CYCLES=3
    next(); ifc.redirect = 1; push_exp();
    for (int i = 0; i < 4; i++) begin next(); idle(); push_exp(); end

    // Redirect and load-use in the same cycle
    next(); ifc.ex_memread = 1; ifc.rd_ex = 7; ifc.rt_dec = 7; ifc.redirect = 1; push_exp();
    for (int i = 0; i < 4; i++) begin next(); idle(); push_exp(); end

    // Reset while waiting on a miss with a deferred redirect
    next(); ifc.mem_req = 1; ifc.redirect = 1; push_exp();
    next(); ifc.redirect = 0; push_exp();
    next(); RST = 1'b1; push_exp();
    next(); RST = 1'b0; idle(); push_exp();
    for (int i = 0; i < 4; i++) begin next(); push_exp(); end

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      next();
      RST              = ($urandom_range(0, 299) == 0);
      ifc.rs_dec       = 5'($urandom_range(0, 3));
      ifc.rt_dec       = 5'($urandom_range(0, 3));
      ifc.rs_ex        = 5'($urandom_range(0, 3));
      ifc.rt_ex        = 5'($urandom_range(0, 3));
      ifc.rd_ex        = 5'($urandom_range(0, 3));
      ifc.rw_mem       = 5'($urandom_range(0, 3));
      ifc.rw_wb        = 5'($urandom_range(0, 3));
      ifc.ex_memread   = ($urandom_range(0, 2) == 0);
      ifc.mem_regwrite = $urandom_range(0, 1);
      ifc.wb_regwrite  = $urandom_range(0, 1);
      ifc.mem_req      = ($urandom_range(0, 2) == 0);
      ifc.dhit         = ($urandom_range(0, 4) < 3);
      ifc.redirect     = ($urandom_range(0, 9) == 0);
      push_exp();
    end
    next(); RST = 1'b0; idle(); push_exp();

    @(negedge CLK);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d pending required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
